// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and feeder state encoding for the systolic datapath
package tpu_pkg;

  localparam int DATA_SIZE = 8;
  localparam int MAC_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - enable-gated shift register; chain=0 drains stages past stage 0 with zeros
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             chain,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] first
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Single-stage lines never shift past stage 0, so chain has no effect there.
  logic unused_chain;
  assign unused_chain = chain;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= chain ? stage[i-1] : '0;
    end
  end

  assign dout  = stage[DEPTH-1];
  assign first = stage[0];

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skews ROWS-wide column vectors into a diagonal wavefront for the MAC array
module systolic_skew_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE,
  parameter int ROWS   = MAC_WIDTH,
  parameter int CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   in_last,
  input  logic                   skew_en,
  input  logic                   out_ready,
  output logic [ROWS*DATA_W-1:0] out_data,
  output logic [ROWS-1:0]        out_lane_valid,
  output logic                   out_valid,
  output logic                   out_last,
  output logic                   busy,
  output logic [CNT_W-1:0]       vec_count
);

  localparam int FC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [FC_W-1:0] FLUSH_SKEW = FC_W'(ROWS - 1);

  feeder_state_e    state, state_d;
  logic             skew_q, skew_d;
  logic [FC_W-1:0]  flush_cnt, flush_d;
  logic [CNT_W-1:0] vec_d;
  logic             adv, acc;
  logic             tag_dout, tag_first;

  assign adv      = out_ready;
  assign in_ready = reset & out_ready & (state != FLUSH);
  assign acc      = in_valid & in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      skew_q    <= 1'b1;
      flush_cnt <= '0;
      vec_count <= '0;
    end else begin
      state     <= state_d;
      skew_q    <= skew_d;
      flush_cnt <= flush_d;
      vec_count <= vec_d;
    end
  end

  always_comb begin
    state_d = state;
    skew_d  = skew_q;
    flush_d = flush_cnt;
    vec_d   = vec_count;
    unique case (state)
      IDLE: begin
        if (acc) begin
          skew_d = skew_en;
          vec_d  = CNT_W'(1);
          if (in_last) begin
            state_d = FLUSH;
            flush_d = skew_en ? FLUSH_SKEW : '0;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (acc) begin
          vec_d = vec_count + CNT_W'(1);
          if (in_last) begin
            state_d = FLUSH;
            flush_d = skew_q ? FLUSH_SKEW : '0;
          end
        end
      end
      FLUSH: begin
        // A count of 1 reaching 0 and a count loaded as 0 both end the flush on this advance.
        if (adv) begin
          if (flush_cnt <= FC_W'(1)) state_d = IDLE;
          if (flush_cnt != '0) flush_d = flush_cnt - FC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [DATA_W:0] lane_din, lane_dout, lane_first, lane_sel;

    assign lane_din = acc ? {1'b1, in_data[i*DATA_W +: DATA_W]} : '0;

    skew_delay_line #(
      .WIDTH(DATA_W + 1),
      .DEPTH(i + 1)
    ) u_line (
      .clock(clock),
      .reset(reset),
      .en   (adv),
      .chain(skew_q),
      .din  (lane_din),
      .dout (lane_dout),
      .first(lane_first)
    );

    assign lane_sel                     = skew_q ? lane_dout : lane_first;
    assign out_data[i*DATA_W +: DATA_W] = lane_sel[DATA_W-1:0];
    assign out_lane_valid[i]            = lane_sel[DATA_W];
  end

  // The last-vector tag rides a line as deep as the slowest lane so it lands with that lane's element.
  skew_delay_line #(
    .WIDTH(1),
    .DEPTH(ROWS)
  ) u_tag (
    .clock(clock),
    .reset(reset),
    .en   (adv),
    .chain(skew_q),
    .din  (acc & in_last),
    .dout (tag_dout),
    .first(tag_first)
  );

  assign out_last  = skew_q ? tag_dout : tag_first;
  assign out_valid = |out_lane_valid;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - scoreboard bench for systolic_skew_feeder at ROWS=4, DATA_W=8
module tb_systolic_skew_feeder;

  localparam int ROWS = 4;
  localparam int DW   = 8;
  localparam int CW   = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [ROWS*DW-1:0] in_data = '0;
  logic               in_last = 1'b0;
  logic               skew_en = 1'b1;
  logic               out_ready = 1'b0;
  logic [ROWS*DW-1:0] out_data;
  logic [ROWS-1:0]    out_lane_valid;
  logic               out_valid;
  logic               out_last;
  logic               busy;
  logic [CW-1:0]      vec_count;

  always #5 clock = ~clock;

  systolic_skew_feeder #(.DATA_W(DW), .ROWS(ROWS), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .skew_en(skew_en), .out_ready(out_ready),
    .out_data(out_data), .out_lane_valid(out_lane_valid), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .vec_count(vec_count)
  );

  typedef struct packed {
    logic [ROWS*DW-1:0] data;
    logic [ROWS-1:0]    lv;
    logic               last;
    logic               busy;
    logic [CW-1:0]      vc;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Model: every advance appends one column; lane i shows the column i advances back.
  logic [ROWS*DW-1:0] hdata[$];
  logic [ROWS-1:0]    hval[$];
  logic               hlast[$];
  logic               m_skew = 1'b1;
  logic               m_in_tile = 1'b0;
  int                 m_flush = 0;
  logic [CW-1:0]      m_vc = '0;
  exp_t               sb[$];

  localparam logic [ROWS*DW-1:0] VA = 32'h04030201;
  localparam logic [ROWS*DW-1:0] VB = 32'h08070605;
  localparam logic [ROWS*DW-1:0] VS = 32'h09090909;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   n;
    int   li;
    n = hdata.size();
    e = '0;
    for (int i = 0; i < ROWS; i++) begin
      int idx;
      idx = m_skew ? n - 1 - i : n - 1;
      if (idx >= 0) begin
        e.data[i*DW +: DW] = hdata[idx][i*DW +: DW];
        e.lv[i]            = hval[idx][i];
      end
    end
    li = m_skew ? n - ROWS : n - 1;
    if (li >= 0) e.last = hlast[li];
    e.busy = m_in_tile || (m_flush > 0);
    e.vc   = m_vc;
    return e;
  endfunction

  task automatic model_reset();
    hdata.delete(); hval.delete(); hlast.delete(); sb.delete();
    m_skew = 1'b1; m_in_tile = 1'b0; m_flush = 0; m_vc = '0;
  endtask

  task automatic step(input logic v, input logic [ROWS*DW-1:0] d, input logic l,
                      input logic sk, input logic ordy);
    logic acc, exp_rdy;
    exp_t e;
    in_valid = v; in_data = d; in_last = l; skew_en = sk; out_ready = ordy;
    #1;
    exp_rdy = ordy && (m_flush == 0);
    check("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clock);
    if (ordy) begin
      if (m_flush > 0) m_flush--;
      if (acc) begin
        if (!m_in_tile) begin
          m_skew = sk;
          m_vc   = 1;
        end else begin
          m_vc = m_vc + 1'b1;
        end
        if (l) begin
          m_in_tile = 1'b0;
          m_flush   = m_skew ? ROWS - 1 : 1;
        end else begin
          m_in_tile = 1'b1;
        end
      end
      hdata.push_back(acc ? d : '0);
      hval.push_back(acc ? {ROWS{1'b1}} : '0);
      hlast.push_back(acc && l);
    end
    sb.push_back(model_out());
    @(negedge clock);
    e = sb.pop_front();
    check("out_data", out_data, e.data);
    check("out_lane_valid", out_lane_valid, e.lv);
    check("out_valid", out_valid, |e.lv);
    check("out_last", out_last, e.last);
    check("busy", busy, e.busy);
    check("vec_count", vec_count, e.vc);
  endtask

  task automatic idle(input int n, input logic sk);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, sk, 1'b1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data"}, out_data, '0);
    check({tag, "_lv"}, out_lane_valid, '0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_last"}, out_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_vc"}, vec_count, '0);
    check({tag, "_rdy"}, in_ready, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 check_cleared("reset");
    @(negedge clock);
    reset = 1'b1;
    idle(2, 1'b1);

    // Skewed two-vector tile
    step(1'b1, VA, 1'b0, 1'b1, 1'b1);
    step(1'b1, VB, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);
    check("t1_lane3", out_data[31:24], 8'd8);
    check("t1_last", out_last, 1'b1);
    check("t1_idle", busy, 1'b0);
    check("t1_vc", vec_count, 16'd2);
    idle(4, 1'b1);

    // Bypass tile
    step(1'b1, VA, 1'b0, 1'b0, 1'b1);
    check("t2_a", out_data, VA);
    step(1'b1, VB, 1'b1, 1'b0, 1'b1);
    check("t2_b_last", out_last, 1'b1);
    idle(1, 1'b0);
    check("t2_idle", busy, 1'b0);
    idle(4, 1'b1);

    // Backpressure mid-flush
    step(1'b1, VA, 1'b0, 1'b1, 1'b1);
    step(1'b1, VB, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Bubble between A and B
    step(1'b1, VA, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b1, VB, 1'b1, 1'b1, 1'b1);
    idle(5, 1'b1);

    // Reset while flushing, then a fresh tile
    step(1'b1, VA, 1'b0, 1'b1, 1'b1);
    step(1'b1, VB, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("t5_flushing", busy, 1'b1);
    reset = 1'b0;
    #1 check_cleared("midreset");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, VA, 1'b0, 1'b1, 1'b1);
    step(1'b1, VB, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);
    check("t5_vc", vec_count, 16'd2);
    idle(4, 1'b1);

    // Single-vector tile
    step(1'b1, VS, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);
    check("t6_lane3", out_data[31:24], 8'd9);
    check("t6_last", out_last, 1'b1);
    check("t6_idle", busy, 1'b0);
    check("t6_vc", vec_count, 16'd1);
    idle(4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
